// File: rtl/dm_cache_ctrl.sv
// Direct-mapped read cache controller with single-cycle lookup and line refill.
// Optional hit/miss statistics counters are built when CACHE_STATS_EN is defined.
module dm_cache_ctrl #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 16,
   parameter int LINES      = 8,
   parameter int LINE_WORDS = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req,
   input  logic [ADDR_W-1:0] cpu_addr,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_ready,
   input  logic              flush,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_rvalid,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [31:0]       hit_cnt,
   output logic [31:0]       miss_cnt
);

   localparam int OFF_W = $clog2(LINE_WORDS);
   localparam int IDX_W = $clog2(LINES);
   localparam int TAG_W = ADDR_W - 1 - OFF_W - IDX_W;
   localparam logic [OFF_W-1:0] LAST = OFF_W'(LINE_WORDS - 1);

   typedef enum logic [1:0] {
      IDLE,
      LOOKUP,
      REFILL
   } state_t;

   state_t state, state_nx;

   logic [TAG_W-1:0]  req_tag;
   logic [IDX_W-1:0]  req_idx;
   logic [OFF_W-1:0]  req_word;
   logic [OFF_W-1:0]  beat;
   logic [LINES-1:0]  valid;
   logic              cancel;
   logic [DATA_W-1:0] cap;

   logic [TAG_W-1:0]  tag_arr  [LINES];
   logic [DATA_W-1:0] data_arr [LINES*LINE_WORDS];

   logic hit;
   logic accept;
   logic beat_acc;
   logic last_beat;
   logic unused_addr0;

   // The byte offset within a 2-byte word never affects the lookup.
   assign unused_addr0 = cpu_addr[0];

   assign accept    = cpu_req && !cpu_ready;
   assign hit       = valid[req_idx] && (tag_arr[req_idx] == req_tag);
   assign beat_acc  = (state == REFILL) && mem_rvalid;
   assign last_beat = beat_acc && (beat == LAST);

   assign mem_req  = (state == REFILL);
   assign mem_addr = mem_req ? {req_tag, req_idx, beat, 1'b0} : '0;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // Next-state decode.
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (accept) state_nx = LOOKUP;
         LOOKUP:  state_nx = hit ? IDLE : REFILL;
         REFILL:  if (last_beat) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Request latch, beat counter, valid bits and response registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         req_tag   <= '0;
         req_idx   <= '0;
         req_word  <= '0;
         beat      <= '0;
         valid     <= '0;
         cancel    <= 1'b0;
         cap       <= '0;
         cpu_rdata <= '0;
         cpu_ready <= 1'b0;
      end else begin
         cpu_ready <= 1'b0;
         unique case (state)
            IDLE: begin
               if (accept) begin
                  req_tag  <= cpu_addr[ADDR_W-1:OFF_W+IDX_W+1];
                  req_idx  <= cpu_addr[OFF_W+IDX_W:OFF_W+1];
                  req_word <= cpu_addr[OFF_W:1];
               end
            end
            LOOKUP: begin
               if (hit) begin
                  cpu_rdata <= data_arr[{req_idx, req_word}];
                  cpu_ready <= 1'b1;
               end else begin
                  beat   <= '0;
                  cancel <= 1'b0;
               end
            end
            REFILL: begin
               if (flush) cancel <= 1'b1;
               if (beat_acc) begin
                  beat <= beat + 1'b1;
                  if (beat == req_word) cap <= mem_rdata;
               end
               if (last_beat) begin
                  cpu_ready <= 1'b1;
                  cpu_rdata <= (beat == req_word) ? mem_rdata : cap;
                  if (!cancel && !flush) valid[req_idx] <= 1'b1;
               end
            end
            default: ;
         endcase
         if (flush) valid <= '0;
      end
   end

   // Tag and data storage; contents are qualified by the valid bits.
   always_ff @(posedge clk) begin
      if (beat_acc) data_arr[{req_idx, beat}] <= mem_rdata;
      if (last_beat) tag_arr[req_idx] <= req_tag;
   end

`ifdef CACHE_STATS_EN
   logic lookup;
   assign lookup = (state == LOOKUP);

   // Saturating hit/miss counters, cleared only by reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hit_cnt  <= '0;
         miss_cnt <= '0;
      end else if (lookup) begin
         if (hit && hit_cnt != '1)    hit_cnt  <= hit_cnt + 1'b1;
         if (!hit && miss_cnt != '1)  miss_cnt <= miss_cnt + 1'b1;
      end
   end
`else
   assign hit_cnt  = '0;
   assign miss_cnt = '0;
`endif

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Scoreboard bench for dm_cache_ctrl: expected words and refill addresses
// are queued at request time and popped as the DUT responds.
module tb_dm_cache_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        cpu_req;
   logic [31:0] cpu_addr;
   logic [15:0] cpu_rdata;
   logic        cpu_ready;
   logic        flush;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_rvalid;
   logic [15:0] mem_rdata;
   logic [31:0] hit_cnt;
   logic [31:0] miss_cnt;

   int n_chk  = 0;
   int n_fail = 0;

   logic [15:0] mem_img [int];
   logic [15:0] exp_data [$];
   logic [31:0] exp_addr [$];

   dm_cache_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .cpu_req    (cpu_req),
      .cpu_addr   (cpu_addr),
      .cpu_rdata  (cpu_rdata),
      .cpu_ready  (cpu_ready),
      .flush      (flush),
      .mem_req    (mem_req),
      .mem_addr   (mem_addr),
      .mem_rvalid (mem_rvalid),
      .mem_rdata  (mem_rdata),
      .hit_cnt    (hit_cnt),
      .miss_cnt   (miss_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // One read: miss selects refill expectations, gap inserts idle
   // cycles between beats, fl_at/rs_at pulse flush/reset at that beat.
   task automatic rd(input logic [31:0] a, input bit miss, input bit gap,
                     input int fl_at, input int rs_at);
      logic [31:0] base;
      logic [31:0] ea;
      int b;
      bit done;
      base = {a[31:3], 3'b000};
      b = 0;
      done = 0;
      @(negedge clk);
      cpu_req  = 1'b1;
      cpu_addr = a;
      if (rs_at < 0) exp_data.push_back(mem_img[{a[31:1], 1'b0}]);
      if (miss)
         for (int i = 0; i < 4; i++) exp_addr.push_back(base + 32'(2 * i));
      for (int cyc = 1; cyc <= 60 && !done; cyc++) begin
         @(negedge clk);
         mem_rvalid = 1'b0;
         flush      = 1'b0;
         if (!miss) chk("hit_memreq", 32'(mem_req), 0);
         if (cpu_ready) begin
            chk("rdata", 32'(cpu_rdata), 32'(exp_data.pop_front()));
            if (!miss) chk("hit_lat", cyc, 2);
            else if (!gap && fl_at < 0) chk("miss_lat", cyc, 6);
            chk("beats", b, miss ? 4 : 0);
            cpu_req = 1'b0;
            done = 1;
         end else if (mem_req && b == rs_at) begin
            rst = 1'b1;
            #1;
            chk("rst_memreq", 32'(mem_req), 0);
            chk("rst_ready", 32'(cpu_ready), 0);
            cpu_req = 1'b0;
            @(negedge clk);
            rst = 1'b0;
            exp_addr.delete();
            return;
         end else if (mem_req && b < 4) begin
            if (!gap || $urandom_range(0, 1) == 1) begin
               ea = (exp_addr.size() > 0) ? exp_addr.pop_front() : 32'hDEAD;
               chk("mem_addr", mem_addr, ea);
               mem_rvalid = 1'b1;
               mem_rdata  = mem_img[mem_addr];
               if (b == fl_at) flush = 1'b1;
               b++;
            end
         end
      end
      if (!done) chk("timeout", 1, 0);
      @(negedge clk);
      chk("ready_pulse", 32'(cpu_ready), 0);
   endtask

   initial begin
      rst        = 1'b1;
      cpu_req    = 1'b0;
      cpu_addr   = '0;
      flush      = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
      for (int i = 0; i < 4; i++) begin
         mem_img[32'h40 + 2*i] = 16'h1111 * 16'(i + 1);
         mem_img[32'h80 + 2*i] = 16'h00A0 + 16'(i);
      end
      repeat (2) @(negedge clk);
      chk("rst_ready", 32'(cpu_ready), 0);
      chk("rst_rdata", 32'(cpu_rdata), 0);
      chk("rst_memreq", 32'(mem_req), 0);
      chk("rst_memaddr", mem_addr, 0);
      chk("rst_hitcnt", hit_cnt, 0);
      chk("rst_misscnt", miss_cnt, 0);
      rst = 1'b0;

      rd(32'h44, 1, 0, -1, -1);
      rd(32'h43, 0, 0, -1, -1);
`ifdef CACHE_STATS_EN
      chk("hit_cnt", hit_cnt, 1);
      chk("miss_cnt", miss_cnt, 1);
`else
      chk("hit_cnt", hit_cnt, 0);
      chk("miss_cnt", miss_cnt, 0);
`endif

      rd(32'h80, 1, 1, -1, -1);
      rd(32'h44, 1, 1, -1, -1);
      rd(32'h46, 0, 0, -1, -1);

      rd(32'h80, 1, 0, -1, -1);
      rd(32'h44, 1, 0, 1, -1);
      rd(32'h44, 1, 0, -1, -1);
      rd(32'h42, 0, 0, -1, -1);

      rd(32'h80, 1, 0, -1, 2);
      chk("post_rst_hit", hit_cnt, 0);
      chk("post_rst_miss", miss_cnt, 0);
      rd(32'h40, 1, 0, -1, -1);
      rd(32'h40, 0, 0, -1, -1);

      chk("sb_empty", 32'(exp_data.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
